// File: rtl/soin_pkg.sv
// Shared constants and types for the RV32 write-back path.
// Requester encoding doubles as the arbiter request/grant bit index.
package soin_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RAW  = 5;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 = ALU, bit 1 = LSU.
// The priority pointer only moves on a two-way conflict.
module rr_arbiter2
  import soin_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t prio;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio == WB_LSU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // The loser of a conflict becomes the favoured side next time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= WB_LSU;
    end else if (req == 2'b11) begin
      prio <= (prio == WB_LSU) ? WB_ALU : WB_LSU;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back port arbiter plus register busy scoreboard.
// Busy bits stay set until the register file write has landed.
module wb_arbiter
  import soin_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [RAW-1:0]  alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [RAW-1:0]  lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            lsu_ready,
  input  logic            iss_valid,
  input  logic [RAW-1:0]  iss_rd,
  input  logic [RAW-1:0]  rs1,
  input  logic [RAW-1:0]  rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            rf_wen,
  output logic [RAW-1:0]  rf_wnum,
  output logic [XLEN-1:0] rf_wd
);

  localparam logic [NREG-1:0] X0_BIT = NREG'(1);

  logic [1:0]      gnt;
  logic            xfer;
  logic [RAW-1:0]  sel_rd;
  logic [XLEN-1:0] sel_wd;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_valid, alu_valid}),
    .gnt (gnt)
  );

  assign alu_ready = gnt[0] && !rst;
  assign lsu_ready = gnt[1] && !rst;
  assign xfer      = alu_ready || lsu_ready;
  assign sel_rd    = lsu_ready ? lsu_rd : alu_rd;
  assign sel_wd    = lsu_ready ? lsu_wd : alu_wd;

  assign hazard = busy[rs1] || busy[rs2]
               || (iss_valid && busy[iss_rd]);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && !hazard) set_mask[iss_rd] = 1'b1;
    if (rf_wen) clr_mask[rf_wnum] = 1'b1;
  end

  // Set is applied after clear so a fresh producer wins a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~X0_BIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen  <= 1'b0;
      rf_wnum <= '0;
      rf_wd   <= '0;
    end else if (xfer) begin
      rf_wen  <= (sel_rd != '0);
      rf_wnum <= sel_rd;
      rf_wd   <= sel_wd;
    end else begin
      rf_wen  <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and register scoreboard for the RV32 core. Shares the register file's single write port (Wen/Wnum/Wd) between the ALU and load/store unit (LSU) write-back requesters, using round-robin on conflict. Tracks destination registers with pending writes so that decode stalls on RAW/WAW hazards. The register file has no write-to-read bypass, so a busy bit stays set until the write has actually landed.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count (x0 hardwired zero)
- RAW, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_rd  in  RAW  ALU destination index
- alu_wd  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- lsu_valid / lsu_rd / lsu_wd / lsu_ready  same as ALU set, for the LSU
- iss_valid  in  1  decode issues an instruction with a destination
- iss_rd  in  RAW  destination of the issuing instruction
- rs1, rs2  in  RAW  source indices of the instruction in decode
- hazard  out  1  decode must stall (combinational)
- busy  out  NREG  scoreboard bitmap (registered)
- rf_wen, rf_wnum, rf_wd  out  1/RAW/XLEN  registered drive to the register file write port

## Operation
- Handshake: a transfer occurs when valid && ready. Once a requester asserts valid, it holds valid, rd, and wd stable until ready is asserted.
- Arbitration: grant at most one requester per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the grant goes to the side named by the priority flag `prio` (reset value = LSU). After any two-way conflict, `prio` flips to the loser.
  - `prio` is unchanged when there is no conflict.
- ready = grant && !rst. The non-granted side sees ready=0.
- Accepted transfer: rf_wnum <= rd and rf_wd <= wd at the next edge.
  - rf_wen <= (rd != 0). Writes to x0 are accepted and consumed, but never reach the register file.
  - With no transfer, rf_wen <= 0, and rf_wnum/rf_wd hold their values.
- Scoreboard, busy[r]:
  - Set at the edge where iss_valid && !hazard && iss_rd == r && r != 0.
  - Cleared at the edge where rf_wen && rf_wnum == r, which is the same edge at which the register file commits the write.
  - If set and clear hit the same r on the same edge, set wins (a new producer is outstanding).
  - busy[0] is constantly 0.
- hazard = busy[rs1] || busy[rs2] || (iss_valid && busy[iss_rd]). Index 0 never causes a hazard. iss_valid is ignored while hazard=1.
- A write-back to a register that is not busy is still performed. There is no error flag.

## Timing
- Reset (async assert, sync-safe deassert): busy=0, rf_wen=0, rf_wnum=0, rf_wd=0, prio=LSU. alu_ready and lsu_ready are forced to 0 while rst=1.
- Accept at edge N → rf_* valid during cycle N+1 → register file written at edge N+1 → busy bit clears at edge N+1 → a decode read in cycle N+2 sees the new value with hazard=0.
- Throughput: one write-back per cycle. The loser of a conflict is granted next cycle if it is still valid.
- Reset asserted mid-operation: an in-flight rf_wen is dropped, all busy bits clear, and requesters must re-present.
- Issue → write-back minimum: busy is set at edge I. The earliest clear is at edge I+1, if the write-back is accepted in the same cycle as the issue; busy is 1 during cycle I+1 regardless.

## Structure
- Shared package soin_pkg holds:
  - XLEN, NREG, and RAW constants.
  - Requester enum wb_src_t {WB_ALU, WB_LSU}, used for `prio` and the grant.
- Sub-module rr_arbiter2 is a 2-input round-robin arbiter: req[1:0] in, gnt[1:0] out, plus the internal `prio` flop and the rule that `prio` flips only on conflict.
- Top level contains the write-port register stage, the NREG-bit scoreboard, and the hazard compare logic.

## Test plan
- Reset: with rst=1 and alu_valid=lsu_valid=1 → both ready=0, rf_wen=0, busy=0. After release, the first conflict grants LSU.
- Conflict: alu(rd=3, wd=0x11) and lsu(rd=4, wd=0x22) both held valid → cycle 1: lsu_ready=1 and rf_wnum=4 / rf_wd=0x22 on the next cycle. Cycle 2: alu_ready=1 and rf_wnum=3 / rf_wd=0x11. A third conflict grants LSU again.
- x0: alu(rd=0, wd=0xDEAD) → alu_ready=1, rf_wen stays 0, busy unchanged.
- RAW stall: issue rd=5 → busy[5]=1. Decode with rs1=5 → hazard=1. LSU writes rd=5 with 0x55 → hazard=0 two cycles after the accept, and the register file reads 0x55.
- Set/clear collision: re-issue rd=7 on the same edge that rf_wen commits x7 → busy[7] remains 1.
- Mid-operation reset: busy=0x0000_00A0 with a pending rf_wen → assert rst asynchronously → busy=0 and rf_wen=0 immediately, without waiting for a clock edge.
